// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: accepts fetch addresses, reads the 1-cycle instruction BRAM,
// and queues {pc, instruction} pairs for decode. Define IFB_STALL_CNT_EN to add the stall_cnt port.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [31:0]              pc_in,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  output logic                     imem_ena,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  output logic [31:0]              ins_data,
  output logic [31:0]              ins_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   occ;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   mem_pc  [DEPTH];
  logic [31:0]   mem_ins [DEPTH];
  logic          clear;
  logic          accept;
  logic          push;
  logic          pop;

  // Occupancy includes the outstanding read so its return always has a slot.
  assign occ      = cnt + {{AW{1'b0}}, inflight};
  assign clear    = flush | ~start;
  assign pc_ready = ~reset & start & ~flush & (occ < (AW+1)'(DEPTH));
  assign accept   = pc_valid & pc_ready;
  assign imem_ena = accept;
  assign imem_addr = {pc_in[31:2], 2'b00};

  assign push      = inflight & ~clear;
  assign ins_valid = (cnt != '0);
  assign pop       = ins_valid & ins_ready & ~clear;
  assign ins_data  = mem_ins[rd_ptr];
  assign ins_pc    = mem_pc[rd_ptr];
  assign count     = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept)
        inflight_pc <= pc_in;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]  <= '0;
        mem_ins[i] <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]  <= inflight_pc;
      mem_ins[wr_ptr] <= imem_rdata;
    end
  end

`ifdef IFB_STALL_CNT_EN
  logic stall;
  assign stall = start & pc_valid & ~pc_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
